// File: rtl/uart_byte_tx_if.sv
// Byte-in / serial-out handshake bundle for uart_byte_tx.
// master = byte producer, slave = transmitter.
interface uart_byte_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 uart_tx;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, uart_tx, tx_busy, tx_done
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, uart_tx, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_byte_tx.sv
// UART transmitter: one byte per valid/ready handshake, serialised LSB first as 8N1/8N2.
// Define UART_TX_PARITY_EN to add a parity bit (PARITY_ODD selects odd parity).
module uart_byte_tx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    uart_byte_tx_if.slave    tx
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int CW       = $clog2(BAUD_DIV);
    localparam int BW       = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    logic accept;
    logic bit_end;

    assign tx.tx_ready = (state_q == IDLE) && !sys_rst;
    assign tx.uart_tx  = tx_q;
    assign tx.tx_busy  = (state_q != IDLE);
    assign tx.tx_done  = done_q;

    assign accept  = tx.tx_valid && tx.tx_ready;
    assign bit_end = (cnt_q == CW'(BAUD_DIV - 1));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // tx_d is the line level for the next cycle, so every transition sets the new bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    state_d = START;
                    shift_d = tx.tx_data;
                    tx_d    = 1'b0;
                    cnt_d   = '0;
                    bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                    par_d   = (^tx.tx_data) ^ PARITY_ODD;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == BW'(DATA_BITS - 1)) begin
                        bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = par_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (bit_q == BW'(STOP_BITS - 1)) begin
                        state_d = IDLE;
                        bit_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx: DIV=10 instances with 1 and 2 stop bits,
// per-cycle line model plus a byte scoreboard decoded from mid-bit samples.
module tb_uart_byte_tx;
    localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart_byte_tx_if #(.DATA_BITS(8)) if0 ();
    uart_byte_tx_if #(.DATA_BITS(8)) if1 ();

    uart_byte_tx #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .STOP_BITS(1)
`ifdef UART_TX_PARITY_EN
        , .PARITY_ODD(1'b0)
`endif
    ) u0 (.sys_clk(clk), .sys_rst(rst), .tx(if0));

    uart_byte_tx #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .STOP_BITS(2)
`ifdef UART_TX_PARITY_EN
        , .PARITY_ODD(1'b1)
`endif
    ) u1 (.sys_clk(clk), .sys_rst(rst), .tx(if1));

    logic [7:0] sb0[$];
    logic [7:0] sb1[$];
    int passed = 0;
    int total  = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic get_tx(input int w);
        return (w == 0) ? if0.uart_tx : if1.uart_tx;
    endfunction
    function automatic logic get_busy(input int w);
        return (w == 0) ? if0.tx_busy : if1.tx_busy;
    endfunction
    function automatic logic get_done(input int w);
        return (w == 0) ? if0.tx_done : if1.tx_done;
    endfunction
    function automatic logic get_ready(input int w);
        return (w == 0) ? if0.tx_ready : if1.tx_ready;
    endfunction

    task automatic drive(input int w, input logic [7:0] d, input logic v);
        if (w == 0) begin
            if0.tx_data = d; if0.tx_valid = v;
        end else begin
            if1.tx_data = d; if1.tx_valid = v;
        end
    endtask

    // Expected line level c clocks after the accept edge (c=1 is the first start-bit clock).
    function automatic logic exp_line(input int c, input logic [7:0] b, input logic odd);
        int idx;
        if (c < 1) return 1'b1;
        idx = (c - 1) / DIV;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (P == 1 && idx == 9) return (^b) ^ odd;
        return 1'b1;
    endfunction

    task automatic send(input int w, input logic [7:0] d, input logic hold);
        drive(w, d, 1'b1);
        chk("pre_accept_ready", get_ready(w), 1);
        tick;
        if (w == 0) sb0.push_back(d); else sb1.push_back(d);
        if (!hold) drive(w, d, 1'b0);
    endtask

    // Walks one frame from clock 1 to the first IDLE clock (L+1); leaves time there.
    task automatic run_frame(input int w, input int stopb, input logic odd,
                             input int poke_c, input logic [7:0] poke_d,
                             output int start_cyc);
        int L;
        logic [7:0] exp_b;
        logic [7:0] got;
        L = (1 + 8 + P + stopb) * DIV;
        exp_b = (w == 0) ? sb0[0] : sb1[0];
        got = '0;
        start_cyc = cyc;
        for (int c = 1; c <= L + 1; c++) begin
            if (c == poke_c)     drive(w, poke_d, 1'b1);
            if (c == poke_c + 1) drive(w, poke_d, 1'b0);
            chk($sformatf("line_w%0d_c%0d", w, c), get_tx(w), exp_line(c, exp_b, odd));
            chk($sformatf("busy_w%0d_c%0d", w, c), get_busy(w), (c <= L) ? 1 : 0);
            chk($sformatf("done_w%0d_c%0d", w, c), get_done(w), (c == L + 1) ? 1 : 0);
            chk($sformatf("ready_w%0d_c%0d", w, c), get_ready(w), (c == L + 1) ? 1 : 0);
            if (c > DIV && c <= 9 * DIV && (c - 1) % DIV == DIV / 2)
                got[(c - 1) / DIV - 1] = get_tx(w);
            if (c <= L) tick;
        end
        if (w == 0) chk("decoded_w0", got, sb0.pop_front());
        else        chk("decoded_w1", got, sb1.pop_front());
    endtask

    initial begin
        int s1, s2;
        drive(0, 8'h00, 1'b0);
        drive(1, 8'h00, 1'b0);
        rst = 1'b1;
        repeat (3) tick;
        for (int w = 0; w < 2; w++) begin
            chk("rst_tx", get_tx(w), 1);
            chk("rst_ready", get_ready(w), 0);
            chk("rst_busy", get_busy(w), 0);
            chk("rst_done", get_done(w), 0);
        end
        rst = 1'b0;
        #1;
        chk("rel_ready_w0", get_ready(0), 1);
        chk("rel_ready_w1", get_ready(1), 1);
        tick;

        // single frame
        send(0, 8'h55, 1'b0);
        run_frame(0, 1, 1'b0, -5, 8'h00, s1);
        tick;
        chk("idle_tx", get_tx(0), 1);
        chk("idle_busy", get_busy(0), 0);
        tick;

        // back-to-back with tx_valid held
        send(0, 8'hA3, 1'b1);
        drive(0, 8'h0F, 1'b1);
        run_frame(0, 1, 1'b0, -5, 8'h00, s1);
        sb0.push_back(8'h0F);
        tick;
        drive(0, 8'h0F, 1'b0);
        run_frame(0, 1, 1'b0, -5, 8'h00, s2);
        chk("b2b_gap", s2 - s1, (1 + 8 + P + 1) * DIV + 1);
        tick;

        // data change and stray valid pulse mid-frame
        send(0, 8'h12, 1'b0);
        run_frame(0, 1, 1'b0, 30, 8'hFF, s1);
        for (int i = 0; i < 15; i++) begin
            tick;
            chk("no_extra_frame_tx", get_tx(0), 1);
            chk("no_extra_frame_busy", get_busy(0), 0);
        end

        // reset at clock 35 of a frame
        send(0, 8'h5A, 1'b0);
        repeat (34) tick;
        rst = 1'b1;
        #1;
        chk("midrst_tx", get_tx(0), 1);
        chk("midrst_busy", get_busy(0), 0);
        chk("midrst_ready", get_ready(0), 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("midrst_done", get_done(0), 0);
            chk("midrst_tx_hold", get_tx(0), 1);
        end
        rst = 1'b0;
        #1;
        chk("postrst_ready", get_ready(0), 1);
        void'(sb0.pop_front());
        tick;
        send(0, 8'h3C, 1'b0);
        run_frame(0, 1, 1'b0, -5, 8'h00, s1);
        tick;

        // two stop bits
        send(1, 8'h00, 1'b0);
        run_frame(1, 2, 1'b1, -5, 8'h00, s1);
        tick;

`ifdef UART_TX_PARITY_EN
        send(0, 8'h07, 1'b0);
        run_frame(0, 1, 1'b0, -5, 8'h00, s1);
        tick;
        send(1, 8'h03, 1'b0);
        run_frame(1, 2, 1'b1, -5, 8'h00, s1);
        tick;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_byte_tx.md
Name: uart_byte_tx

Overview:
UART transmit engine: the outbound counterpart of the uart_rx path in uart_top.
- Accepts one byte per valid/ready handshake and serialises it onto uart_tx as 8N1 (optionally with parity), LSB first, at a parameterised baud rate.
- Sits between the uart_top command/loopback logic and the uart_tx pin; runs on the sys_clk domain.

Parameters:
CLK_FREQ, 50_000_000, sys_clk frequency in Hz.
BAUD_RATE, 115200, line rate in bit/s; BAUD_DIV = CLK_FREQ/BAUD_RATE (integer truncation); BAUD_DIV >= 2 is required.
DATA_BITS, 8, data bits per frame (5..8).
STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
sys_clk  input  1  system clock, all logic on its rising edge.
sys_rst  input  1  asynchronous, active-high reset.
tx_data  input  DATA_BITS  byte to send; sampled only on handshake.
tx_valid  input  1  tx_data is valid.
tx_ready  output  1  high when the block can accept a byte (IDLE only).
uart_tx  output  1  serial line, idle high.
tx_busy  output  1  high while a frame is in progress (START..STOP).
tx_done  output  1  one-cycle pulse after the final stop bit completes.

Behaviour:
- Reset (async assert, sync release): state=IDLE, uart_tx=1, tx_ready=0 while sys_rst is high, tx_busy=0, tx_done=0, baud counter=0, bit index=0.
- After release, tx_ready=1 in IDLE.
- Handshake: accept when tx_valid && tx_ready on a rising edge. tx_data is latched into the shift register. tx_ready drops the next cycle.
  - tx_valid without tx_ready is held off with no effect.
  - tx_data changes after acceptance are ignored.
- FSM:
  - IDLE -> START on accept.
  - START: uart_tx=0 for BAUD_DIV clocks, then -> DATA.
  - DATA: uart_tx=shift[0], shifting right every BAUD_DIV clocks, for DATA_BITS bits, then -> PARITY (feature on) or STOP.
  - PARITY: one bit for BAUD_DIV clocks, then -> STOP.
  - STOP: uart_tx=1 for STOP_BITS*BAUD_DIV clocks, then -> IDLE.
- Latency: uart_tx falls on the cycle after the accept edge. Each bit lasts exactly BAUD_DIV clocks, counted 0..BAUD_DIV-1; the counter wraps to 0 at every bit boundary.
- Frame length is (1+DATA_BITS+P+STOP_BITS)*BAUD_DIV clocks, where P=1 with parity, else 0.
- tx_busy=1 exactly while state != IDLE.
- tx_done pulses for one clock on the first IDLE cycle after STOP; tx_ready=1 in that same cycle.
- Back-to-back: with tx_valid held high, the next byte is accepted in that first IDLE cycle. Inter-frame idle gap is the stop bit(s) plus exactly 1 clock.
- Reset mid-frame: frame abandoned, uart_tx forced to 1 immediately (async), no tx_done.
- uart_tx is driven from a register; no glitches.

Optional Feature:
UART_TX_PARITY_EN
- Defined: adds parameter PARITY_ODD (default 0 = even). The PARITY state sends the XOR of the latched data bits, inverted when PARITY_ODD=1. The frame grows by BAUD_DIV clocks.
- Undefined: no PARITY state or logic; the frame is start+data+stop only.

Test Plan:
1. CLK_FREQ=1_000_000, BAUD_RATE=100_000 (DIV=10), send 0x55 -> uart_tx is low 10 clk, then bits 1,0,1,0,1,0,1,0 each 10 clk, then high. tx_done pulses at clock 101 after accept; tx_busy is high for clocks 1..100.
2. Send 0xA3, then hold tx_valid with 0x0F -> second start bit falls exactly 101 clocks after the first. Decoded bytes are 0xA3, 0x0F; tx_ready is low throughout each frame.
3. Change tx_data 0x12 -> 0xFF mid-frame -> transmitted bits still decode 0x12. A tx_valid pulse while busy is ignored: only one frame is sent.
4. Assert sys_rst at clock 35 of a frame for 3 clocks -> uart_tx is 1 within the same cycle, no tx_done. tx_ready=1 on the first clock after release; a following 0x3C transmits correctly.
5. STOP_BITS=2, send 0x00 -> line high for 20 clocks after the last data bit; tx_done at clock 111.
6. UART_TX_PARITY_EN defined, PARITY_ODD=0, send 0x07 -> parity bit=1, frame 110 clocks. PARITY_ODD=1, send 0x03 -> parity bit=1.
